// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning HI/LO with multi-cycle busy timing.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   tmp_q, tmp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   div_rt, quo_u, rem_u, rs_mag, rt_mag, quo_m, rem_m, quo_s, rem_s;
  logic          div_z;
  assign busy = cnt_q != '0;
  assign hi = hi_q;
  assign lo = lo_q;
  assign out = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;
  assign acc = start && !busy && !req && reset;
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'b0, rs} * {32'b0, rt};
  // Divisor forced to 1 on divide-by-zero only to keep the datapath X-free; result is discarded.
  assign div_z = rt == '0;
  assign div_rt = div_z ? 32'd1 : rt;
  assign quo_u = rs / div_rt;
  assign rem_u = rs % div_rt;
  assign rs_mag = rs[31] ? -rs : rs;
  assign rt_mag = rt[31] ? -rt : div_rt;
  assign quo_m = rs_mag / rt_mag;
  assign rem_m = rs_mag % rt_mag;
  assign quo_s = (rs[31] ^ rt[31]) ? -quo_m : quo_m;
  assign rem_s = rs[31] ? -rem_m : rem_m;
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    tmp_d = tmp_q;
    cnt_d = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) {hi_d, lo_d} = tmp_q;
    end
    // HI/LO cannot change while busy, so a divide by zero simply re-latches them.
    if (acc) begin
      case (op)
        OP_MULT:  begin tmp_d = prod_s; cnt_d = CW'(MULT_CYCLES); end
        OP_MULTU: begin tmp_d = prod_u; cnt_d = CW'(MULT_CYCLES); end
        OP_DIV:   begin tmp_d = div_z ? {hi_q, lo_q} : {rem_s, quo_s}; cnt_d = CW'(DIV_CYCLES); end
        OP_DIVU:  begin tmp_d = div_z ? {hi_q, lo_q} : {rem_u, quo_u}; cnt_d = CW'(DIV_CYCLES); end
        OP_MTHI:  hi_d = rs;
        OP_MTLO:  lo_d = rs;
`ifdef MDU_MADD_EN
        OP_MADD:  begin tmp_d = {hi_q, lo_q} + prod_s; cnt_d = CW'(MULT_CYCLES); end
        OP_MADDU: begin tmp_d = {hi_q, lo_q} + prod_u; cnt_d = CW'(MULT_CYCLES); end
        OP_MSUB:  begin tmp_d = {hi_q, lo_q} - prod_s; cnt_d = CW'(MULT_CYCLES); end
        OP_MSUBU: begin tmp_d = {hi_q, lo_q} - prod_u; cnt_d = CW'(MULT_CYCLES); end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      tmp_q <= '0;
      cnt_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      tmp_q <= tmp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
